// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: widths, size codes,
// FSM states and the memory command payload.
package mem_port_arbiter_pkg;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    localparam int unsigned MAX_D_STREAK_DEF = 4;
    localparam int unsigned TIMEOUT_DEF      = 16;

    // Access size codes (funct3[1:0]); 2'b11 is illegal and reported as misaligned
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    typedef struct packed {
        logic           we;
        logic [BEW-1:0] be;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } mem_cmd_t;

    // Memory is word addressed: clear the byte offset
    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] a);
        return {a[AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_be_gen.sv
// Store lane steering: byte enables, replicated lane data and misalignment flag.
module mem_port_arbiter_be_gen
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]     size,
    input  logic [1:0]     addr_lo,
    input  logic [DW-1:0]  wdata,
    output logic [BEW-1:0] be_c,
    output logic [DW-1:0]  lane_data_c,
    output logic           misalign_c
);

    // Decode size and low address bits into lane enables and replicated data
    always_comb begin
        be_c        = '0;
        lane_data_c = wdata;
        misalign_c  = 1'b0;
        case (size)
            SZ_B: begin
                be_c        = 4'b0001 << addr_lo;
                lane_data_c = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be_c        = 4'b0011 << {addr_lo[1], 1'b0};
                lane_data_c = {2{wdata[15:0]}};
                misalign_c  = addr_lo[0];
            end
            SZ_W: begin
                be_c        = 4'b1111;
                misalign_c  = (addr_lo != 2'b00);
            end
            default: begin
                misalign_c  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// load/store unit: one transaction at a time, D priority with a bounded streak,
// misalignment rejection and a hung-memory timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [AW-1:0]  if_addr,
    output logic           if_ack,
    output logic [DW-1:0]  if_rdata,
    output logic           if_err,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [1:0]     d_size,
    input  logic [AW-1:0]  d_addr,
    input  logic [DW-1:0]  d_wdata,
    output logic           d_ack,
    output logic [DW-1:0]  d_rdata,
    output logic           d_err,
    output logic           m_req,
    output logic           m_we,
    output logic [BEW-1:0] m_be,
    output logic [AW-1:0]  m_addr,
    output logic [DW-1:0]  m_wdata,
    input  logic [DW-1:0]  m_rdata,
    input  logic           m_ready
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t         state_q, state_d;
    mem_cmd_t       cmd_q, cmd_d;
    logic [SW-1:0]  streak_q, streak_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           m_req_d;
    logic           if_ack_d, if_err_d, d_ack_d, d_err_d;
    logic [DW-1:0]  if_rdata_d, d_rdata_d;

    logic           if_req_m, d_req_m, grant_d;
    logic [BEW-1:0] be_c;
    logic [DW-1:0]  lane_c;
    logic           misalign_c;

    mem_port_arbiter_be_gen u_be_gen (
        .size        (d_size),
        .addr_lo     (d_addr[1:0]),
        .wdata       (d_wdata),
        .be_c        (be_c),
        .lane_data_c (lane_c),
        .misalign_c  (misalign_c)
    );

    // A requester is ignored in the cycle its own ack is visible
    assign if_req_m = if_req & ~if_ack;
    assign d_req_m  = d_req & ~d_ack;
    assign grant_d  = d_req_m & (~if_req_m | (streak_q != SW'(MAX_D_STREAK)));

    assign m_we    = cmd_q.we;
    assign m_be    = cmd_q.be;
    assign m_addr  = cmd_q.addr;
    assign m_wdata = cmd_q.wdata;

    // Next-state, next-output and counter update logic
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        streak_d   = streak_q;
        tmo_d      = tmo_q;
        m_req_d    = 1'b0;
        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (grant_d) begin
                    // Streak only grows while fetch is actually being held off
                    streak_d = if_req_m ? SW'(streak_q + SW'(1)) : '0;
                    if (misalign_c) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        cmd_d.we    = d_we;
                        cmd_d.be    = d_we ? be_c : 4'b1111;
                        cmd_d.addr  = word_addr(d_addr);
                        cmd_d.wdata = d_we ? lane_c : '0;
                        m_req_d     = 1'b1;
                        state_d     = ST_BUSY_D;
                    end
                end else if (if_req_m) begin
                    streak_d    = '0;
                    cmd_d.we    = 1'b0;
                    cmd_d.be    = 4'b1111;
                    cmd_d.addr  = word_addr(if_addr);
                    cmd_d.wdata = '0;
                    m_req_d     = 1'b1;
                    state_d     = ST_BUSY_IF;
                end
            end

            ST_BUSY_IF, ST_BUSY_D: begin
                // m_ready takes precedence over a simultaneous timeout
                if (m_ready) begin
                    state_d = ST_ACK;
                    if (state_q == ST_BUSY_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_rdata;
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = m_rdata;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_ACK;
                    if (state_q == ST_BUSY_IF) begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                    end else begin
                        d_ack_d  = 1'b1;
                        d_err_d  = 1'b1;
                    end
                end else begin
                    m_req_d = 1'b1;
                    tmo_d   = TW'(tmo_q + TW'(1));
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            streak_q <= '0;
            tmo_q    <= '0;
            m_req    <= 1'b0;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            m_req    <= m_req_d;
            if_ack   <= if_ack_d;
            if_err   <= if_err_d;
            d_ack    <= d_ack_d;
            d_err    <= d_err_d;
            if_rdata <= if_rdata_d;
            d_rdata  <= d_rdata_d;
        end
    end

endmodule
